// File: rtl/pipe_stage_buf.sv
// Generic inter-stage pipeline buffer: opaque payload, valid/ready handshake,
// optional skid entry, sticky halt tracking and a saturating stall counter.
module pipe_stage_buf #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_halt,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_halt,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    occ_e              state_q, state_d;
    logic [DATA_W-1:0] head_data_q, head_data_d;
    logic              head_halt_q, head_halt_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              skid_halt_q, skid_halt_d;
    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic accept_s;
    logic deliver_s;
    logic stall_inc_s;

    assign out_valid = (state_q != OCC_EMPTY);
    assign out_data  = head_data_q;
    assign out_halt  = head_halt_q;
    assign occupancy = state_q;
    assign stall_cnt = stall_q;

    assign accept_s    = in_valid & in_ready;
    assign deliver_s   = out_valid & out_ready;
    assign stall_inc_s = out_valid & ~out_ready & ~flush;

    // DEPTH=1 passes downstream ready through; DEPTH=2 uses registers only
    generate
        if ((DEPTH != 1 && DEPTH != 2) || DATA_W < 1 || DATA_W > 1024 || CNT_W < 1) begin : g_bad_param
            $error("pipe_stage_buf: DEPTH must be 1 or 2, DATA_W 1..1024, CNT_W >= 1");
            assign in_ready = 1'b0;
        end else if (DEPTH == 1) begin : g_depth1
            assign in_ready = nRST & ~halted_q & (~out_valid | out_ready);
        end else begin : g_depth2
            assign in_ready = nRST & ~halted_q & (state_q != OCC_FULL);
        end
    endgenerate

    // Next-state for occupancy FSM, entry storage, halt flag and stall counter
    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_halt_d = head_halt_q;
        skid_data_d = skid_data_q;
        skid_halt_d = skid_halt_q;
        halted_d    = halted_q;
        stall_d     = stall_q;

        if (stall_inc_s && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end else begin
            stall_d = stall_q;
        end

        if (flush) begin
            // The squashed bubble is an all-zero NOP; same-cycle input is dropped
            state_d     = OCC_EMPTY;
            head_data_d = '0;
            head_halt_d = 1'b0;
            skid_data_d = '0;
            skid_halt_d = 1'b0;
            halted_d    = 1'b0;
        end else begin
            halted_d = halted_q | (accept_s & in_halt);
            case (state_q)
                OCC_EMPTY: begin
                    if (accept_s) begin
                        head_data_d = in_data;
                        head_halt_d = in_halt;
                        state_d     = OCC_ONE;
                    end else begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_ONE: begin
                    if (accept_s && deliver_s) begin
                        head_data_d = in_data;
                        head_halt_d = in_halt;
                    end else if (accept_s && (DEPTH == 2)) begin
                        skid_data_d = in_data;
                        skid_halt_d = in_halt;
                        state_d     = OCC_FULL;
                    end else if (deliver_s) begin
                        head_data_d = '0;
                        head_halt_d = 1'b0;
                        state_d     = OCC_EMPTY;
                    end else begin
                        state_d = OCC_ONE;
                    end
                end
                OCC_FULL: begin
                    if (deliver_s) begin
                        head_data_d = skid_data_q;
                        head_halt_d = skid_halt_q;
                        skid_data_d = '0;
                        skid_halt_d = 1'b0;
                        state_d     = OCC_ONE;
                    end else begin
                        state_d = OCC_FULL;
                    end
                end
                default: begin
                    state_d     = OCC_EMPTY;
                    head_data_d = '0;
                    head_halt_d = 1'b0;
                    skid_data_d = '0;
                    skid_halt_d = 1'b0;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q     <= OCC_EMPTY;
            head_data_q <= '0;
            head_halt_q <= 1'b0;
            skid_data_q <= '0;
            skid_halt_q <= 1'b0;
            halted_q    <= 1'b0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            head_data_q <= head_data_d;
            head_halt_q <= head_halt_d;
            skid_data_q <= skid_data_d;
            skid_halt_q <= skid_halt_d;
            halted_q    <= halted_d;
            stall_q     <= stall_d;
        end
    end

endmodule
